// File: rtl/boot_loader.sv
// boot_loader: copies LENGTH 16-bit words from a combinational program ROM into RAM
// starting at DEST_BASE, holding the CPU in reset until the copy completes.
//
// Ports:
//   clk              - single clock, all state changes on the rising edge
//   reset            - synchronous, active-high reset
//   rom_address      - ROM word address (always the current word counter)
//   rom_data         - ROM word, combinationally valid for rom_address
//   ram_address      - RAM write address (latched in FETCH)
//   ram_data_out     - RAM write data (latched in FETCH)
//   ram_write_enable - write request, high only in WRITE
//   ram_ready        - RAM accepts the write on an edge where it and the enable are high
//   cpu_reset        - high until the copy is done
//   done             - copy complete
//   checksum         - modulo-2^16 sum of all words accepted by the RAM
module boot_loader #(
   parameter int unsigned LENGTH    = 45,
   parameter logic [15:0] DEST_BASE = 16'h2000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [9:0]  rom_address,
   input  logic [15:0] rom_data,
   output logic [15:0] ram_address,
   output logic [15:0] ram_data_out,
   output logic        ram_write_enable,
   input  logic        ram_ready,
   output logic        cpu_reset,
   output logic        done,
   output logic [15:0] checksum
);

   typedef enum logic [1:0] {StIdle, StFetch, StWrite, StDone} state_e;

   // Index of the final word; LENGTH is limited to 1..1024 so this fits in 10 bits.
   localparam logic [9:0] LastIdx = 10'(LENGTH - 1);

   state_e      state_q, state_d;
   logic [9:0]  count_q, count_d;
   logic [15:0] ram_address_q, ram_address_d;
   logic [15:0] ram_data_q, ram_data_d;
   logic [15:0] checksum_q, checksum_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= StIdle;
         count_q       <= 10'd0;
         ram_address_q <= 16'h0000;
         ram_data_q    <= 16'h0000;
         checksum_q    <= 16'h0000;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         ram_address_q <= ram_address_d;
         ram_data_q    <= ram_data_d;
         checksum_q    <= checksum_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      ram_address_d = ram_address_q;
      ram_data_d    = ram_data_q;
      checksum_d    = checksum_q;
      case (state_q)
         StIdle: begin
            state_d = StFetch;
         end
         StFetch: begin
            ram_data_d    = rom_data;
            // 16-bit add wraps naturally past 16'hffff
            ram_address_d = DEST_BASE + {6'b000000, count_q};
            state_d       = StWrite;
         end
         StWrite: begin
            // Address and data stay frozen until the RAM takes the word
            if (ram_ready) begin
               checksum_d = checksum_q + ram_data_q;
               if (count_q == LastIdx) begin
                  state_d = StDone;
               end else begin
                  count_d = count_q + 10'd1;
                  state_d = StFetch;
               end
            end
         end
         StDone: begin
            state_d = StDone;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign rom_address      = count_q;
   assign ram_address      = ram_address_q;
   assign ram_data_out     = ram_data_q;
   assign checksum         = checksum_q;
   assign ram_write_enable = (state_q == StWrite);
   assign done             = (state_q == StDone);
   assign cpu_reset        = (state_q != StDone);

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: three instances (default parameters, LENGTH=1,
// wrapping DEST_BASE). Expected writes are queued when a copy is started; per-instance
// monitors pop and compare on every accepted write.
module tb_boot_loader;

   typedef struct packed {
      logic [15:0] a;
      logic [15:0] d;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- instance A: default parameters ----------------
   logic        reset_a;
   logic        ready_a = 1'b1;
   logic [9:0]  rom_address_a;
   logic [15:0] rom_data_a, ram_address_a, ram_data_out_a, checksum_a;
   logic        we_a, cpu_reset_a, done_a;
   logic [15:0] rom_a [0:1023];

   assign rom_data_a = rom_a[rom_address_a];

   boot_loader u_dut_a (
      .clk              (clk),
      .reset            (reset_a),
      .rom_address      (rom_address_a),
      .rom_data         (rom_data_a),
      .ram_address      (ram_address_a),
      .ram_data_out     (ram_data_out_a),
      .ram_write_enable (we_a),
      .ram_ready        (ready_a),
      .cpu_reset        (cpu_reset_a),
      .done             (done_a),
      .checksum         (checksum_a)
   );

   // ---------------- instance B: LENGTH=1 ----------------
   logic        reset_b;
   logic [9:0]  rom_address_b;
   logic [15:0] rom_data_b, ram_address_b, ram_data_out_b, checksum_b;
   logic        we_b, cpu_reset_b, done_b;

   assign rom_data_b = (rom_address_b == 10'd0) ? 16'h8000 : 16'hbeef;

   boot_loader #(.LENGTH(1), .DEST_BASE(16'h2000)) u_dut_b (
      .clk              (clk),
      .reset            (reset_b),
      .rom_address      (rom_address_b),
      .rom_data         (rom_data_b),
      .ram_address      (ram_address_b),
      .ram_data_out     (ram_data_out_b),
      .ram_write_enable (we_b),
      .ram_ready        (1'b1),
      .cpu_reset        (cpu_reset_b),
      .done             (done_b),
      .checksum         (checksum_b)
   );

   // ---------------- instance C: wrapping destination ----------------
   logic        reset_c;
   logic [9:0]  rom_address_c;
   logic [15:0] rom_data_c, ram_address_c, ram_data_out_c, checksum_c;
   logic        we_c, cpu_reset_c, done_c;

   assign rom_data_c = {6'h03, rom_address_c};

   boot_loader #(.LENGTH(20), .DEST_BASE(16'hfff0)) u_dut_c (
      .clk              (clk),
      .reset            (reset_c),
      .rom_address      (rom_address_c),
      .rom_data         (rom_data_c),
      .ram_address      (ram_address_c),
      .ram_data_out     (ram_data_out_c),
      .ram_write_enable (we_c),
      .ram_ready        (1'b1),
      .cpu_reset        (cpu_reset_c),
      .done             (done_c),
      .checksum         (checksum_c)
   );

   wr_t exp_a[$];
   wr_t exp_b[$];
   wr_t exp_c[$];

   // ---------------- stall driver and word-5 observers for A ----------------
   logic stall_en  = 1'b0;
   int   stall_cnt = 0;
   int   w5_cycles = 0;
   int   w5_bad    = 0;
   int   acc5      = 0;

   always @(posedge clk) begin
      #1;
      if (stall_en && we_a && ram_address_a == 16'h2005 && stall_cnt < 3) begin
         ready_a = 1'b0;
         stall_cnt++;
      end else begin
         ready_a = 1'b1;
      end
   end

   always @(negedge clk) begin
      if (we_a && ram_address_a == 16'h2005) begin
         w5_cycles++;
         if (ram_data_out_a !== rom_a[5]) w5_bad++;
      end
   end

   // ---------------- monitors ----------------
   always @(negedge clk) begin
      wr_t e;
      if (we_a && ready_a) begin
         chk("a_addr_range", {31'd0, ram_address_a >= 16'h2000 && ram_address_a <= 16'h202c},
             32'd1);
         if (ram_address_a == 16'h2005) acc5++;
         if (exp_a.size() == 0) begin
            chk("a_unexpected_write", ram_address_a, 32'hffffffff);
         end else begin
            e = exp_a.pop_front();
            chk("a_wr_addr", ram_address_a, e.a);
            chk("a_wr_data", ram_data_out_a, e.d);
         end
      end
   end

   always @(negedge clk) begin
      wr_t e;
      if (we_b) begin
         if (exp_b.size() == 0) begin
            chk("b_unexpected_write", ram_address_b, 32'hffffffff);
         end else begin
            e = exp_b.pop_front();
            chk("b_wr_addr", ram_address_b, e.a);
            chk("b_wr_data", ram_data_out_b, e.d);
         end
      end
   end

   always @(negedge clk) begin
      wr_t e;
      if (we_c) begin
         chk("c_addr_range", {31'd0, ram_address_c >= 16'hfff0 || ram_address_c <= 16'h0003},
             32'd1);
         if (exp_c.size() == 0) begin
            chk("c_unexpected_write", ram_address_c, 32'hffffffff);
         end else begin
            e = exp_c.pop_front();
            chk("c_wr_addr", ram_address_c, e.a);
            chk("c_wr_data", ram_data_out_c, e.d);
         end
      end
   end

   // ---------------- helpers for A ----------------
   task automatic check_reset_vals_a(input string tag);
      chk({tag, "_rom_address"}, rom_address_a, 32'd0);
      chk({tag, "_ram_address"}, ram_address_a, 32'd0);
      chk({tag, "_ram_data"}, ram_data_out_a, 32'd0);
      chk({tag, "_checksum"}, checksum_a, 32'd0);
      chk({tag, "_we"}, we_a, 32'd0);
      chk({tag, "_cpu_reset"}, cpu_reset_a, 32'd1);
      chk({tag, "_done"}, done_a, 32'd0);
   endtask

   task automatic push_exp_a(output logic [15:0] sum);
      wr_t e;
      exp_a.delete();
      sum = 16'h0000;
      for (int i = 0; i < 45; i++) begin
         e.a = 16'h2000 + 16'(i);
         e.d = rom_a[i];
         exp_a.push_back(e);
         sum = sum + rom_a[i];
      end
   endtask

   // Expects reset_a high on entry; releases it and runs the whole copy.
   task automatic run_copy_a(input string tag, input int exp_lat);
      logic [15:0] sum;
      int lat;
      push_exp_a(sum);
      @(negedge clk);
      reset_a = 1'b0;
      @(posedge clk);  // IDLE -> FETCH
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!done_a && lat < 3000);
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_checksum"}, checksum_a, sum);
      chk({tag, "_pending"}, exp_a.size(), 32'd0);
      chk({tag, "_cpu_reset"}, cpu_reset_a, 32'd0);
      chk({tag, "_last_addr"}, ram_address_a, 32'h202c);
   endtask

   logic bc_fin = 1'b0;

   // ---------------- main sequence for A ----------------
   initial begin
      int          k;
      int          pulses;
      int          cr_hi;
      logic [15:0] cs_hold;
      logic [9:0]  ra_hold;

      for (int i = 0; i < 1024; i++) rom_a[i] = 16'h0000;
      rom_a[0] = 16'h8000;
      for (int i = 1; i < 44; i++) rom_a[i] = 16'h8000 ^ 16'(i * 16'h0123);
      rom_a[44] = 16'h0000;

      reset_a = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset_vals_a("rst");

      // Full copy, RAM always ready
      run_copy_a("copy1", 90);

      // DONE is absorbing: no writes, CPU released, state frozen
      cs_hold = checksum_a;
      ra_hold = rom_address_a;
      pulses  = 0;
      cr_hi   = 0;
      repeat (100) begin
         @(negedge clk);
         if (we_a) pulses++;
         if (cpu_reset_a || !done_a) cr_hi++;
      end
      chk("done_we_pulses", pulses, 32'd0);
      chk("done_cpu_reset", cr_hi, 32'd0);
      chk("done_checksum_frozen", checksum_a, cs_hold);
      chk("done_count_frozen", rom_address_a, ra_hold);

      // Reset in DONE reasserts cpu_reset; copy again with a 3-cycle stall on word 5
      @(negedge clk);
      reset_a = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_in_done_cpu_reset", cpu_reset_a, 32'd1);
      chk("rst_in_done_done", done_a, 32'd0);
      stall_en  = 1'b1;
      stall_cnt = 0;
      w5_cycles = 0;
      w5_bad    = 0;
      acc5      = 0;
      run_copy_a("stall", 93);
      stall_en = 1'b0;
      chk("stall_w5_cycles", w5_cycles, 32'd4);
      chk("stall_w5_stable", w5_bad, 32'd0);
      chk("stall_w5_writes", acc5, 32'd1);

      // Reset pulsed while count=10, then a clean restart
      @(negedge clk);
      reset_a = 1'b1;
      repeat (2) @(posedge clk);
      begin
         logic [15:0] unused_sum;
         push_exp_a(unused_sum);
      end
      @(negedge clk);
      reset_a = 1'b0;
      k = 0;
      while (rom_address_a != 10'd10 && k < 500) begin
         @(negedge clk);
         k++;
      end
      chk("mid_reach_count10", rom_address_a, 32'd10);
      reset_a = 1'b1;
      @(posedge clk);
      #1;
      check_reset_vals_a("mid_rst");
      run_copy_a("restart", 90);

      k = 0;
      while (!bc_fin && k < 2000) begin
         @(posedge clk);
         k++;
      end
      chk("bc_finished", bc_fin, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // ---------------- instances B and C ----------------
   initial begin
      wr_t         e;
      logic [15:0] sum_c;
      int          lat;
      int          lat_b;
      int          lat_c;

      reset_b = 1'b1;
      reset_c = 1'b1;
      repeat (2) @(posedge clk);
      e.a = 16'h2000;
      e.d = 16'h8000;
      exp_b.push_back(e);
      sum_c = 16'h0000;
      for (int i = 0; i < 20; i++) begin
         e.a = 16'hfff0 + 16'(i);
         e.d = {6'h03, 10'(i)};
         exp_c.push_back(e);
         sum_c = sum_c + e.d;
      end
      @(negedge clk);
      reset_b = 1'b0;
      reset_c = 1'b0;
      @(posedge clk);
      lat   = 0;
      lat_b = 0;
      lat_c = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
         if (done_b && lat_b == 0) lat_b = lat;
         if (done_c && lat_c == 0) lat_c = lat;
      end while (!(done_b && done_c) && lat < 500);
      chk("b_latency", lat_b, 32'd2);
      chk("b_checksum", checksum_b, 32'h8000);
      chk("b_pending", exp_b.size(), 32'd0);
      chk("c_latency", lat_c, 32'd40);
      chk("c_checksum", checksum_c, sum_c);
      chk("c_last_addr", ram_address_c, 32'h0003);
      chk("c_pending", exp_c.size(), 32'd0);
      bc_fin = 1'b1;
   end

endmodule
